mem_dma: RTL and testbench

Block-transfer engine sitting directly upstream of the 8-bit data memory. It owns the memory's single port (address, write data, write enable, async read data) while a transfer runs and passes the core's load/store signals through otherwise. It performs ascending byte copies (src→dst) or constant fills so test programs and the sequencer can stage or clear data memory without core instructions.

---
 rtl/dma_pkg.sv | 16 +
 rtl/mem_dma.sv | 147 ++++++++++++++
 tb/tb_mem_dma.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types for the data-memory block-transfer engine.
// State encoding and transfer-mode constants.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FILL,
    DONE
  } dma_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// Block copy / fill engine in front of the single-port data memory.
// Owns the memory port while a transfer runs, else passes core accesses.
module mem_dma
  import dma_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          core_stall,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_data_in,
  input  logic          core_memWrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_memWrite,
  input  logic [DW-1:0] mem_data_out
);

  dma_state_t state_q;
  dma_state_t state_d;

  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [AW-1:0] remaining;
  logic [DW-1:0] buffer;
  logic [DW-1:0] fill_q;
  logic          mode_q;
  logic          last;

  assign last = (remaining == AW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d = DONE;
          end else if (mode == MODE_FILL) begin
            state_d = FILL;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = WRITE;
      WRITE: state_d = last ? DONE : READ;
      FILL:  state_d = last ? DONE : FILL;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured once at start and never re-sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      buffer    <= '0;
      fill_q    <= '0;
      mode_q    <= MODE_COPY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_ptr   <= src;
            dst_ptr   <= dst;
            remaining <= len;
            fill_q    <= fill_val;
            mode_q    <= mode;
          end
        end
        READ: buffer <= mem_data_out;
        WRITE: begin
          src_ptr   <= src_ptr + AW'(1);
          dst_ptr   <= dst_ptr + AW'(1);
          remaining <= remaining - AW'(1);
        end
        FILL: begin
          dst_ptr   <= dst_ptr + AW'(1);
          remaining <= remaining - AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_addr     = core_addr;
    mem_data_in  = core_data_in;
    mem_memWrite = core_memWrite;
    unique case (state_q)
      IDLE: begin
      end
      READ: begin
        busy         = 1'b1;
        mem_addr     = src_ptr;
        mem_data_in  = buffer;
        mem_memWrite = 1'b0;
      end
      WRITE: begin
        busy         = 1'b1;
        mem_addr     = dst_ptr;
        mem_data_in  = buffer;
        mem_memWrite = 1'b1;
      end
      FILL: begin
        busy         = 1'b1;
        mem_addr     = dst_ptr;
        mem_data_in  = fill_q;
        mem_memWrite = 1'b1;
      end
      DONE: begin
        done         = 1'b1;
        mem_memWrite = 1'b0;
      end
      default: begin
        mem_memWrite = 1'b0;
      end
    endcase
  end

  assign core_stall = busy;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma with a behavioural memory image model.
// Directed test-plan cases followed by randomized copies and fills.
module tb_mem_dma;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic       core_stall;
  logic [7:0] core_addr;
  logic [7:0] core_data_in;
  logic       core_memWrite;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_memWrite;
  logic [7:0] mem_data_out;

  logic [7:0] mem  [256];
  logic [7:0] refm [256];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_dma #(.AW(8), .DW(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .fill_val     (fill_val),
    .busy         (busy),
    .done         (done),
    .core_stall   (core_stall),
    .core_addr    (core_addr),
    .core_data_in (core_data_in),
    .core_memWrite(core_memWrite),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_memWrite (mem_memWrite),
    .mem_data_out (mem_data_out)
  );

  assign mem_data_out = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_memWrite) mem[mem_addr] <= mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== refm[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0)
      $display("  first differing byte at %0h: %0h vs %0h",
               first, mem[first], refm[first]);
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic clear_inputs();
    start         = 1'b0;
    core_memWrite = 1'b0;
  endtask

  // One complete transfer, checked cycle by cycle against the
  // documented schedule, then the whole memory image is compared.
  task automatic xfer(input string tag, input logic md,
                      input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] l, input logic [7:0] fv,
                      input bit noise);
    int t;
    logic [7:0] ea;
    logic       ewe;
    for (int k = 0; k < int'(l); k++) begin
      if (md) refm[d + 8'(k)] = fv;
      else    refm[d + 8'(k)] = refm[s + 8'(k)];
    end
    t = (l == 0) ? 0 : (md ? int'(l) : 2 * int'(l));
    @(negedge clock);
    mode     = md;
    src      = s;
    dst      = d;
    len      = l;
    fill_val = fv;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 0; c <= t; c++) begin
      @(negedge clock);
      if (c == t) begin
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk({tag, ".we_done"}, 32'(mem_memWrite), 32'd0);
      end else begin
        if (md) begin
          ea  = d + 8'(c);
          ewe = 1'b1;
        end else if (c % 2 == 0) begin
          ea  = s + 8'(c / 2);
          ewe = 1'b0;
        end else begin
          ea  = d + 8'(c / 2);
          ewe = 1'b1;
        end
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".stall"}, 32'(core_stall), 32'd1);
        chk({tag, ".done0"}, 32'(done), 32'd0);
        chk({tag, ".addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, ".we"}, 32'(mem_memWrite), 32'(ewe));
        if (md) chk({tag, ".wdata"}, 32'(mem_data_in), 32'(fv));
        if (noise && c < t - 1) begin
          start         = 1'b1;
          mode          = ~md;
          src           = 8'($urandom);
          dst           = 8'($urandom);
          len           = 8'($urandom);
          fill_val      = 8'($urandom);
          core_memWrite = 1'b1;
          core_addr     = 8'($urandom);
          core_data_in  = 8'($urandom);
        end else begin
          clear_inputs();
        end
      end
    end
    @(negedge clock);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk_mem({tag, ".mem"});
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    mode          = 1'b0;
    src           = '0;
    dst           = '0;
    len           = '0;
    fill_val      = '0;
    core_addr     = 8'h33;
    core_data_in  = 8'h44;
    core_memWrite = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'($urandom);
      refm[i] = mem[i];
    end
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.stall", 32'(core_stall), 32'd0);
    chk("rst.we", 32'(mem_memWrite), 32'(core_memWrite));
    chk("rst.addr", 32'(mem_addr), 32'h33);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle pass-through store from the core.
    @(negedge clock);
    core_addr     = 8'h77;
    core_data_in  = 8'h3C;
    core_memWrite = 1'b1;
    #1;
    chk("pt.addr", 32'(mem_addr), 32'h77);
    chk("pt.data", 32'(mem_data_in), 32'h3C);
    chk("pt.we", 32'(mem_memWrite), 32'd1);
    refm[8'h77] = 8'h3C;
    @(negedge clock);
    core_memWrite = 1'b0;
    chk_mem("pt.mem");

    xfer("fill", 1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 1'b0);

    @(negedge clock);
    mem[8'h20] = 8'h11; refm[8'h20] = 8'h11;
    mem[8'h21] = 8'h22; refm[8'h21] = 8'h22;
    mem[8'h22] = 8'h33; refm[8'h22] = 8'h33;
    xfer("copy", 1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 1'b0);

    xfer("wrap", 1'b1, 8'h00, 8'hFE, 8'd3, 8'h7E, 1'b0);

    @(negedge clock);
    mem[8'h50] = 8'h9C; refm[8'h50] = 8'h9C;
    xfer("ovl", 1'b0, 8'h50, 8'h51, 8'd3, 8'h00, 1'b1);

    xfer("len0", 1'b0, 8'h10, 8'h90, 8'd0, 8'hEE, 1'b0);

    // Reset in the write cycle of byte 1 of a 4-byte copy.
    @(negedge clock);
    mode  = 1'b0;
    src   = 8'h60;
    dst   = 8'h70;
    len   = 8'd4;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    core_addr = 8'hC1;
    reset     = 1'b1;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.addr", 32'(mem_addr), 32'hC1);
    chk("mrst.we", 32'(mem_memWrite), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    refm[8'h70] = refm[8'h60];
    repeat (10) @(negedge clock);
    chk("mrst.idle", 32'(busy), 32'd0);
    chk_mem("mrst.mem");

    // Randomized transfers, including overlapping and wrapping ranges.
    for (int n = 0; n < 24; n++) begin
      xfer("rnd", 1'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom_range(0, 24)), 8'($urandom), bit'($urandom));
    end
    xfer("big", 1'b0, 8'($urandom), 8'($urandom), 8'd255, 8'h00, 1'b0);
    xfer("bigf", 1'b1, 8'h00, 8'($urandom), 8'd255, 8'h5A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
